stereo_line_buffer: RTL

- Upstream neighbour of the SAD stage.
- Takes the raster-ordered 8-bit grayscale pixel streams from both cameras, which are frame-synchronised and share one hcount/vcount.
- Stores the last KERNEL_SIZE-1 lines of each camera in line RAMs.
- Emits, per pixel, a vertical column of KERNEL_SIZE pixels per camera, with hcount/vcount re-tagged to the column's centre row.

---
 rtl/stereo_line_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/stereo_line_buffer.sv
// Stereo line buffer: per-camera ring of KERNEL_SIZE line RAMs emitting a vertical pixel column per accepted pixel.
// Optional macro STEREO_LB_ZERO_PAD_EN: emit top rows early with not-yet-written rows forced to zero.
module stereo_line_buffer #(
  parameter int KERNEL_SIZE = 3,
  parameter int HRES        = 1280,
  parameter int VRES        = 720
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [7:0]                   pixel_cam1,
  input  logic [7:0]                   pixel_cam2,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         data_valid_in,
  output logic [KERNEL_SIZE-1:0][7:0]  data_cam1,
  output logic [KERNEL_SIZE-1:0][7:0]  data_cam2,
  output logic [10:0]                  hcount_out,
  output logic [9:0]                   vcount_out,
  output logic                         data_valid_out
);

  localparam int SW   = $clog2(KERNEL_SIZE);
  localparam int AW   = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int HALF = (KERNEL_SIZE - 1) / 2;
  localparam logic [SW-1:0] LAST = SW'(KERNEL_SIZE - 1);

  if (KERNEL_SIZE < 3 || (KERNEL_SIZE % 2) == 0) begin : g_bad_kernel
    $error("stereo_line_buffer: KERNEL_SIZE must be odd and >= 3");
  end
  if (HRES < 1 || HRES > 2047 || VRES < KERNEL_SIZE || VRES > 1024) begin : g_bad_res
    $error("stereo_line_buffer: HRES/VRES out of range for 11/10-bit counters");
  end

  // Maps output row (0 = oldest) to the ring line holding it, relative to the line being written.
  function automatic logic [SW-1:0] ring_idx(input logic [SW-1:0] base, input int row);
    int s;
    s = int'(base) + 1 + row;
    if (s >= KERNEL_SIZE) s -= KERNEL_SIZE;
    return SW'(s);
  endfunction

  logic [7:0] ram_cam1 [KERNEL_SIZE][HRES];
  logic [7:0] ram_cam2 [KERNEL_SIZE][HRES];

  logic          accept, frame_start, line_end, emit;
  logic [SW-1:0] wr_sel, lines_done, wr_sel_eff, lines_eff;
  logic [AW-1:0] addr;

  assign accept      = data_valid_in && (hcount_in < 11'(HRES));
  assign frame_start = accept && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign line_end    = accept && (hcount_in == 11'(HRES - 1));
  assign addr        = hcount_in[AW-1:0];
  assign wr_sel_eff  = frame_start ? '0 : wr_sel;
  assign lines_eff   = frame_start ? '0 : lines_done;
`ifdef STEREO_LB_ZERO_PAD_EN
  assign emit        = (lines_eff >= SW'(HALF));
`else
  assign emit        = (lines_eff == LAST);
`endif

  // Stage p0: acceptance, ring pointer and fill count
  logic vld_p1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_sel     <= '0;
      lines_done <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= accept && emit;
      if (line_end) begin
        wr_sel     <= (wr_sel_eff == LAST) ? '0 : wr_sel_eff + SW'(1);
        lines_done <= (lines_eff == LAST) ? LAST : lines_eff + SW'(1);
      end else if (frame_start) begin
        wr_sel     <= '0;
        lines_done <= '0;
      end
    end
  end

  // Stage p1: RAM write, synchronous reads of every line, live pixel and tags delayed to match
  logic [7:0]    rd_cam1_p1 [KERNEL_SIZE];
  logic [7:0]    rd_cam2_p1 [KERNEL_SIZE];
  logic [7:0]    pix1_p1, pix2_p1;
  logic [10:0]   h_p1;
  logic [9:0]    v_p1;
  logic [SW-1:0] wr_sel_p1;
`ifdef STEREO_LB_ZERO_PAD_EN
  logic [SW-1:0] lines_p1;
`endif

  always_ff @(posedge clk_in) begin
    if (accept) begin
      ram_cam1[wr_sel_eff][addr] <= pixel_cam1;
      ram_cam2[wr_sel_eff][addr] <= pixel_cam2;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        rd_cam1_p1[k] <= ram_cam1[k][addr];
        rd_cam2_p1[k] <= ram_cam2[k][addr];
      end
      pix1_p1   <= pixel_cam1;
      pix2_p1   <= pixel_cam2;
      h_p1      <= hcount_in;
      v_p1      <= vcount_in;
      wr_sel_p1 <= wr_sel_eff;
`ifdef STEREO_LB_ZERO_PAD_EN
      lines_p1  <= lines_eff;
`endif
    end
  end

  // Stage p2: column assembly into registered outputs, held while not valid
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_valid_out <= 1'b0;
      data_cam1      <= '0;
      data_cam2      <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      data_valid_out <= vld_p1;
      if (vld_p1) begin
        hcount_out                 <= h_p1;
        vcount_out                 <= v_p1 - 10'(HALF);
        data_cam1[KERNEL_SIZE-1]   <= pix1_p1;
        data_cam2[KERNEL_SIZE-1]   <= pix2_p1;
        for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
`ifdef STEREO_LB_ZERO_PAD_EN
          data_cam1[i] <= (i < KERNEL_SIZE - 1 - int'(lines_p1)) ? 8'd0
                          : rd_cam1_p1[ring_idx(wr_sel_p1, i)];
          data_cam2[i] <= (i < KERNEL_SIZE - 1 - int'(lines_p1)) ? 8'd0
                          : rd_cam2_p1[ring_idx(wr_sel_p1, i)];
`else
          data_cam1[i] <= rd_cam1_p1[ring_idx(wr_sel_p1, i)];
          data_cam2[i] <= rd_cam2_p1[ring_idx(wr_sel_p1, i)];
`endif
        end
      end
    end
  end

endmodule
